// File: rtl/sub_32b_pipe.sv
// Three-stage pipelined subtractor d = a - b, computed as a + ~b + 1 through
// sectional generate/propagate prefix logic, with valid/ready on both sides.
module sub_32b_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int HI = WIDTH - SPLIT;

    logic             adv1, adv2, adv3;

    logic [WIDTH-1:0] p1_q, g1_q;
    logic             sa1_q, sb1_q, v1_q;

    logic [SPLIT-1:0] lo_g, lo_p, lo_gn, lo_pn, c_lo_d;
    logic [HI-1:0]    hi_g, hi_p, hi_gn, hi_pn, gh_d, ph_d;

    logic [SPLIT-1:0] c2_q;
    logic [HI-1:0]    gh2_q, ph2_q;
    logic [WIDTH-1:0] p2_q;
    logic             sa2_q, sb2_q, v2_q;

    logic [HI-1:0]    c_hi;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] d_d, d_q;
    logic             bout_d, ovf_d, zero_d;
    logic             bout_q, ovf_q, zero_q, v3_q;

    assign adv3     = ~v3_q | out_ready;
    assign adv2     = ~v2_q | adv3;
    assign adv1     = ~v1_q | adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            p1_q  <= '0;
            g1_q  <= '0;
            sa1_q <= 1'b0;
            sb1_q <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                p1_q  <= a ^ ~b;
                g1_q  <= a & ~b;
                sa1_q <= a[WIDTH-1];
                sb1_q <= b[WIDTH-1];
            end
        end
    end

    // Lower section: carry-in of 1 folds into bit 0 as g0 | p0, so the prefix
    // result at each position is already the absolute carry c_i.
    always_comb begin
        lo_g    = g1_q[SPLIT-1:0];
        lo_p    = p1_q[SPLIT-1:0];
        lo_g[0] = g1_q[0] | p1_q[0];
        lo_gn   = lo_g;
        lo_pn   = lo_p;
        for (int s = 1; s < SPLIT; s = s * 2) begin
            lo_gn = lo_g;
            lo_pn = lo_p;
            for (int i = s; i < SPLIT; i++) begin
                lo_gn[i] = lo_g[i] | (lo_p[i] & lo_g[i-s]);
                lo_pn[i] = lo_p[i] & lo_p[i-s];
            end
            lo_g = lo_gn;
            lo_p = lo_pn;
        end
        c_lo_d = lo_g;
    end

    // Upper section: group G/P relative to SPLIT, resolved against c_(SPLIT-1) later.
    always_comb begin
        hi_g  = g1_q[WIDTH-1:SPLIT];
        hi_p  = p1_q[WIDTH-1:SPLIT];
        hi_gn = hi_g;
        hi_pn = hi_p;
        for (int s = 1; s < HI; s = s * 2) begin
            hi_gn = hi_g;
            hi_pn = hi_p;
            for (int i = s; i < HI; i++) begin
                hi_gn[i] = hi_g[i] | (hi_p[i] & hi_g[i-s]);
                hi_pn[i] = hi_p[i] & hi_p[i-s];
            end
            hi_g = hi_gn;
            hi_p = hi_pn;
        end
        gh_d = hi_g;
        ph_d = hi_p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            c2_q  <= '0;
            gh2_q <= '0;
            ph2_q <= '0;
            p2_q  <= '0;
            sa2_q <= 1'b0;
            sb2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                c2_q  <= c_lo_d;
                gh2_q <= gh_d;
                ph2_q <= ph_d;
                p2_q  <= p1_q;
                sa2_q <= sa1_q;
                sb2_q <= sb1_q;
            end
        end
    end

    always_comb begin
        c_hi   = gh2_q | (ph2_q & {HI{c2_q[SPLIT-1]}});
        carry  = {c_hi, c2_q};
        d_d    = p2_q ^ {carry[WIDTH-2:0], 1'b1};
        bout_d = ~carry[WIDTH-1];
        ovf_d  = (sa2_q ^ sb2_q) & (d_d[WIDTH-1] ^ sa2_q);
        zero_d = ~|d_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                d_q    <= d_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sub_32b_pipe.sv
// Randomised and directed bench for sub_32b_pipe against an arithmetic a - b
// reference with an in-order expectation queue.
module tb_sub_32b_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, d;
    logic         bout, ovf, zero;

    sub_32b_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_out = 0;
    logic [W+2:0] exp_q[$];
    int           ts_q[$];
    bit           lat_chk = 0;
    bit           use_lit = 0;
    logic [W+2:0] lit_exp;
    bit           stall_prev = 0;
    logic [W+2:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Reference: plain unsigned/signed arithmetic, packed as {d, bout, ovf, zero}.
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] dd;
        longint       sd, lim;
        logic         bo, ov;
        dd  = x - y;
        bo  = (x < y);
        sd  = longint'($signed(x)) - longint'($signed(y));
        lim = longint'(1) <<< (W - 1);
        ov  = (sd >= lim) || (sd < -lim);
        return {dd, bo, ov, (dd == '0)};
    endfunction

    task automatic cycle();
        logic [W+2:0] obs, e;
        int           t;
        @(negedge clk);
        obs = {d, bout, ovf, zero};
        if (stall_prev) check("hold", obs, held);
        if (out_valid && out_ready) begin
            n_out++;
            check("out_has_expect", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = ts_q.pop_front();
                check("result", obs, e);
                if (lat_chk) check("latency", cyc - t, 3);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(use_lit ? lit_exp : ref_sub(a, b));
            ts_q.push_back(cyc);
            n_acc++;
        end
        stall_prev = out_valid && !out_ready;
        held       = obs;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W+2:0] want);
        int acc0;
        acc0      = n_acc;
        a         = x;
        b         = y;
        lit_exp   = want;
        use_lit   = 1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc == acc0; i++) cycle();
        check("directed_accept", n_acc - acc0, 1);
        use_lit = 0;
        drain();
    endtask

    function automatic logic [W-1:0] gen();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0001_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           k, acc0, out0, sent;
        logic [W-1:0] ra[6], rb[6];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags_d", {d, bout, ovf, zero}, '0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        lat_chk = 1;
        directed(32'h0000_000A, 32'h0000_0003, {32'h0000_0007, 1'b0, 1'b0, 1'b0});
        lat_chk = 0;
        directed(32'h0000_0000, 32'h0000_0001, {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0});
        directed(32'h1234_5678, 32'h1234_5678, {32'h0000_0000, 1'b0, 1'b0, 1'b1});
        directed(32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
        directed(32'h7FFF_FFFF, 32'hFFFF_FFFF, {32'h8000_0000, 1'b1, 1'b1, 1'b0});
        directed(32'h0001_0000, 32'h0000_0001, {32'h0000_FFFF, 1'b0, 1'b0, 1'b0});

        // Backpressure: six pairs into a stalled consumer.
        for (int i = 0; i < 6; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
        out0 = n_out;
        k = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8 && k < 6; i++) begin
            a = ra[k]; b = rb[k];
            acc0 = n_acc;
            cycle();
            if (n_acc != acc0) k++;
        end
        check("bp_accepts", k, 3);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_no_out", n_out - out0, 0);
        out_ready = 1'b1;
        #1 check("bp_in_ready_release", in_ready, 1);
        for (int i = 0; i < 20 && k < 6; i++) begin
            a = ra[k]; b = rb[k];
            acc0 = n_acc;
            cycle();
            if (n_acc != acc0) k++;
        end
        drain();
        check("bp_out_count", n_out - out0, 6);

        // Reset with the pipeline full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin a = $urandom; b = $urandom; cycle(); end
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_d", d, '0);
        exp_q.delete();
        ts_q.delete();
        stall_prev = 0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cycle();
        cycle();
        rst  = 1'b0;
        out0 = n_out;
        for (int i = 0; i < 8; i++) cycle();
        check("no_stale_out", n_out - out0, 0);

        // Random stream under random backpressure.
        sent = 0;
        for (int i = 0; i < 30000 && sent < 1000; i++) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                a = gen();
                b = gen();
            end
            out_ready = ($urandom_range(9) < 7);
            acc0 = n_acc;
            cycle();
            if (n_acc != acc0) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        check("rand_sent", sent, 1000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
